dds_freq_meter: RTL and testbench

Receive-side counterpart of the dds2 sine generator: it consumes a stream of signed sine samples and estimates the DDS phase increment that produced them. The estimate uses the same units as the dds2 `increment` input, cycles per sample × 2^32.
- Detects rising zero crossings with hysteresis over a gated window of valid samples.
- Converts (full periods / samples spanned) into an increment word using a sequential divider.
- Used in loopback self-test (dds2 → dds_freq_meter) and for measuring external tones.

---
 rtl/dds_pkg.sv | 18 +
 rtl/seq_divider.sv | 85 ++++++++
 rtl/dds_freq_meter.sv | 152 +++++++++++++++
 tb/tb_dds_freq_meter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dds_pkg
// Brief    : Constants and meter FSM encoding shared by the dds2 family.
// Revision : 1.0 - initial release
// ============================================================================
package dds_pkg;

    localparam int c_ACC_W  = 32;
    localparam int c_DATA_W = 16;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_MEASURE = 2'd1;
    localparam logic [1:0] c_DIVIDE  = 2'd2;
    localparam logic [1:0] c_FINISH  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : Restoring divider, (preload * 2^Q_W) / divisor, one quotient bit
//            per cycle with all-ones saturation when preload >= divisor.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int PRE_W = 10,
    parameter int DIV_W = 10,
    parameter int Q_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [PRE_W-1:0] i_preload,
    input  logic [DIV_W-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [Q_W-1:0]   o_quotient
);

    localparam int c_REM_W = ((PRE_W > DIV_W) ? PRE_W : DIV_W) + 1;
    localparam int c_CNT_W = $clog2(Q_W) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(Q_W - 1);

    logic [c_REM_W-1:0] r_rem;
    logic [DIV_W-1:0]   r_divisor;
    logic [Q_W-1:0]     r_quot;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_ovf;

    logic               w_load;
    logic               w_last;
    logic               w_ge;
    logic [c_REM_W-1:0] w_src;
    logic [c_REM_W-1:0] w_dvs;
    logic [c_REM_W-1:0] w_shift;
    logic [c_REM_W-1:0] w_diff;

    // The load cycle already produces the first quotient bit from the preload.
    always_comb begin
        w_load  = i_start && !r_busy;
        w_src   = w_load ? c_REM_W'(i_preload) : r_rem;
        w_dvs   = w_load ? c_REM_W'(i_divisor) : c_REM_W'(r_divisor);
        w_shift = {w_src[c_REM_W-2:0], 1'b0};
        w_ge    = (w_shift >= w_dvs);
        w_diff  = w_shift - w_dvs;
        w_last  = w_load ? (Q_W == 1) : (r_cnt == c_CNT_LAST);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem     <= '0;
            r_divisor <= '0;
            r_quot    <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load || r_busy) begin
                r_rem  <= w_ge ? w_diff : w_shift;
                r_quot <= w_load ? Q_W'(w_ge) : {r_quot[Q_W-2:0], w_ge};
                r_cnt  <= w_load ? c_CNT_ONE : r_cnt + c_CNT_ONE;
                r_busy <= !w_last;
                r_done <= w_last;
            end
            if (w_load) begin
                r_divisor <= i_divisor;
                r_ovf     <= (w_src >= w_dvs);
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_ovf ? {Q_W{1'b1}} : r_quot;

endmodule
`default_nettype wire

// File: rtl/dds_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : dds_freq_meter
// Brief    : Estimates the dds2 phase increment of a sine stream from rising
//            hysteresis crossings over a 2^GATE_LOG2 valid-sample window.
// Revision : 1.0 - initial release
// ============================================================================
module dds_freq_meter
    import dds_pkg::*;
#(
    parameter int DATA_W    = c_DATA_W,
    parameter int ACC_W     = c_ACC_W,
    parameter int GATE_LOG2 = 10,
    parameter int HYST      = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    sample_in,
    input  logic                 sample_valid,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_W-1:0]     increment_out,
    output logic [GATE_LOG2-1:0] cycles_out,
    output logic                 no_signal
);

    localparam logic signed [DATA_W-1:0] c_HYST_POS = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] c_HYST_NEG = -c_HYST_POS;
    localparam logic [GATE_LOG2-1:0]     c_ONE      = GATE_LOG2'(1);
    localparam logic [GATE_LOG2-1:0]     c_TWO      = GATE_LOG2'(2);
    localparam logic [GATE_LOG2-1:0]     c_IDX_LAST = '1;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [GATE_LOG2-1:0] r_idx;
    logic [GATE_LOG2-1:0] r_first_idx;
    logic [GATE_LOG2-1:0] r_last_idx;
    logic [GATE_LOG2-1:0] r_ncross;
    logic                 r_armed_low;
    logic                 r_win_end;
    logic [ACC_W-1:0]     r_increment;
    logic [GATE_LOG2-1:0] r_cycles;
    logic                 r_no_signal;

    logic signed [DATA_W-1:0] w_sample;
    logic                 w_active;
    logic                 w_cross;
    logic                 w_measurable;
    logic                 w_div_start;
    logic                 w_div_busy;
    logic                 w_div_done;
    logic [ACC_W-1:0]     w_quotient;
    logic [GATE_LOG2-1:0] w_preload;
    logic [GATE_LOG2-1:0] w_divisor;

    assign w_sample     = sample_in;
    assign w_active     = (r_state == c_MEASURE) && !r_win_end && sample_valid;
    assign w_cross      = w_active && r_armed_low && (w_sample >= c_HYST_POS);
    assign w_measurable = (r_ncross >= c_TWO);
    // The cycle after the last window sample is spent deciding divide vs. no signal.
    assign w_div_start  = (r_state == c_MEASURE) && r_win_end && w_measurable;
    assign w_preload    = r_ncross - c_ONE;
    assign w_divisor    = r_last_idx - r_first_idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:    if (start) w_next_state = c_MEASURE;
            c_MEASURE: if (r_win_end) w_next_state = w_measurable ? c_DIVIDE : c_FINISH;
            c_DIVIDE:  if (w_div_done) w_next_state = c_FINISH;
            c_FINISH:  w_next_state = c_IDLE;
            default:   w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idx       <= '0;
            r_first_idx <= '0;
            r_last_idx  <= '0;
            r_ncross    <= '0;
            r_armed_low <= 1'b0;
            r_win_end   <= 1'b0;
            r_increment <= '0;
            r_cycles    <= '0;
            r_no_signal <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) && start) begin
                r_idx       <= '0;
                r_first_idx <= '0;
                r_last_idx  <= '0;
                r_ncross    <= '0;
                r_armed_low <= 1'b0;
                r_win_end   <= 1'b0;
            end else if (w_active) begin
                r_idx <= r_idx + c_ONE;
                if (r_idx == c_IDX_LAST) r_win_end <= 1'b1;
                if (w_cross) begin
                    r_armed_low <= 1'b0;
                    r_last_idx  <= r_idx;
                    if (r_ncross == '0) r_first_idx <= r_idx;
                    if (r_ncross != c_IDX_LAST) r_ncross <= r_ncross + c_ONE;
                end else if (w_sample <= c_HYST_NEG) begin
                    r_armed_low <= 1'b1;
                end
            end

            // Results land on the edge entering FINISH so they are valid with done.
            if ((r_state == c_MEASURE) && r_win_end && !w_measurable) begin
                r_increment <= '0;
                r_cycles    <= '0;
                r_no_signal <= 1'b1;
            end else if ((r_state == c_DIVIDE) && w_div_done) begin
                r_increment <= w_quotient;
                r_cycles    <= w_preload;
                r_no_signal <= 1'b0;
            end
        end
    end

    seq_divider #(
        .PRE_W (GATE_LOG2),
        .DIV_W (GATE_LOG2),
        .Q_W   (ACC_W)
    ) u_divider (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_start    (w_div_start),
        .i_preload  (w_preload),
        .i_divisor  (w_divisor),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quotient)
    );

    assign busy          = (r_state == c_MEASURE) || (r_state == c_DIVIDE) || w_div_busy;
    assign done          = (r_state == c_FINISH);
    assign increment_out = r_increment;
    assign cycles_out    = r_cycles;
    assign no_signal     = r_no_signal;

endmodule
`default_nettype wire

// File: tb/tb_dds_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_freq_meter
// Brief    : Directed bench for dds_freq_meter with a window-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_freq_meter;

    localparam int          c_BIG  = 1000000000;
    localparam int          c_HYST = 256;
    localparam logic [31:0] c_PH0  = 32'hA000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic        start = 1'b0;
    logic [15:0] sample_in = '0;
    logic        busy;
    logic        done;
    logic        no_signal;
    logic [31:0] increment_out;
    logic [9:0]  cycles_out;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int busy_from = c_BIG;
    int done_at = c_BIG;
    int smp[1024];

    logic [31:0] pend_inc = '0;
    logic [9:0]  pend_cyc = '0;
    logic        pend_nos = 1'b0;
    logic [31:0] held_inc = '0;
    logic [9:0]  held_cyc = '0;
    logic        held_nos = 1'b0;

    dds_freq_meter #(
        .DATA_W    (16),
        .ACC_W     (32),
        .GATE_LOG2 (10),
        .HYST      (c_HYST)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .increment_out (increment_out),
        .cycles_out    (cycles_out),
        .no_signal     (no_signal)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Every cycle: handshake timing plus held results against the model.
    always @(negedge clock) begin
        if (!reset) begin
            held_inc = '0;
            held_cyc = '0;
            held_nos = 1'b0;
        end else if (cyc == done_at) begin
            held_inc = pend_inc;
            held_cyc = pend_cyc;
            held_nos = pend_nos;
        end
        check("busy", 32'(busy), 32'((cyc >= busy_from) && (cyc < done_at)));
        check("done", 32'(done), 32'(reset && (cyc == done_at)));
        check("increment_out", increment_out, held_inc);
        check("cycles_out", 32'(cycles_out), 32'(held_cyc));
        check("no_signal", 32'(no_signal), 32'(held_nos));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int gen(input int mode, input int i, input logic [31:0] inc);
        logic [31:0] ph;
        int          v;
        v = 0;
        case (mode)
            0: begin
                ph = c_PH0 + inc * 32'(i);
                v  = $rtoi(32767.0 * $sin(6.283185307179586 * real'(ph) / 4294967296.0));
            end
            1: v = 1000;
            2: v = (i % 2 == 0) ? 200 : -200;
            default: begin
                if (i == 0) v = -1000;
                else if (i == 500 || i == 1023) v = 1000;
                else if (i > 500) v = -1000;
                else v = 0;
            end
        endcase
        return v;
    endfunction

    task automatic run(input int mode, input logic [31:0] inc, input bit gapped,
                       input bit poke, input bit abort_div, input bit pin,
                       input int pin_cyc, input logic [31:0] pin_inc, input bit pin_nos);
        int                n;
        int                f;
        int                l;
        int                p;
        bit                arm;
        longint unsigned   q;

        for (int i = 0; i < 1024; i++) smp[i] = gen(mode, i, inc);

        n = 0; f = 0; l = 0; arm = 1'b0; p = 0;
        for (int i = 0; i < 1024; i++) begin
            if (arm && smp[i] >= c_HYST) begin
                if (n == 0) f = i;
                l   = i;
                n++;
                arm = 1'b0;
            end else if (smp[i] <= -c_HYST) begin
                arm = 1'b1;
            end
        end
        if (n > 1023) n = 1023;
        if (n < 2) begin
            pend_inc = '0;
            pend_cyc = '0;
            pend_nos = 1'b1;
        end else begin
            q = (longint'(n - 1) << 32) / longint'(l - f);
            if (n - 1 >= l - f) q = 64'hFFFF_FFFF;
            pend_inc = q[31:0];
            pend_cyc = 10'(n - 1);
            pend_nos = 1'b0;
        end
        if (pin) begin
            check("model_cycles", 32'(pend_cyc), 32'(pin_cyc));
            check("model_increment", pend_inc, pin_inc);
            check("model_no_signal", 32'(pend_nos), 32'(pin_nos));
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        busy_from = cyc;
        done_at   = c_BIG;

        for (int i = 0; i < 1024; i++) begin
            sample_in    = 16'(smp[i]);
            sample_valid = 1'b1;
            start        = poke && (i == 100);
            p            = cyc;
            tick();
            start = 1'b0;
            if (gapped && i != 1023) begin
                sample_in    = 16'h7FFF;
                sample_valid = 1'b0;
                tick();
            end
        end
        sample_valid = 1'b0;
        sample_in    = '0;
        // p is the cycle in which the 1024th valid sample was presented.
        done_at = p + (pend_nos ? 2 : 34);

        if (abort_div) begin
            repeat (10) tick();
            busy_from = c_BIG;
            done_at   = c_BIG;
            reset = 1'b0;
            tick();
            reset = 1'b1;
            repeat (40) tick();
            return;
        end

        if (poke) begin
            while (cyc < done_at) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        while (cyc < done_at + 3) tick();
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        run(0, 32'h0800_0000, 0, 0, 0, 1, 31, 32'h0800_0000, 0);
        run(0, 32'h0008_0000, 0, 0, 0, 1, 0, 32'h0, 1);
        run(1, 32'h0, 0, 0, 0, 1, 0, 32'h0, 1);
        run(2, 32'h0, 0, 0, 0, 1, 0, 32'h0, 1);
        run(0, 32'h0800_0000, 1, 0, 0, 1, 31, 32'h0800_0000, 0);
        run(3, 32'h0, 0, 0, 0, 1, 1, 32'd8212174, 0);
        run(0, 32'h0800_0000, 0, 0, 1, 0, 0, 32'h0, 0);
        run(0, 32'h0800_0000, 0, 0, 0, 1, 31, 32'h0800_0000, 0);
        run(0, 32'h0800_0000, 0, 1, 0, 1, 31, 32'h0800_0000, 0);

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
